// File: rtl/dtmr_fault_ctrl_pkg.sv
// Shared types and constants for the DTMR fault controller.
// Holds the FSM encoding, the copy count and a counter-width helper.
package dtmr_pkg;
  localparam int NCOPY = 3;

  typedef enum logic [1:0] {
    ST_SIMPLEX  = 2'd0,
    ST_TMR      = 2'd1,
    ST_RECOVER  = 2'd2,
    ST_FAILSAFE = 2'd3
  } fsm_e;

  // Bits needed to hold the values 0..n-1 (never less than 1).
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dtmr_fault_ctrl_if.sv
// Voter/controller-side signal bundle for the DTMR fault controller.
// master drives act_req/fault; slave (the controller) drives the rest.
interface dtmr_fault_ctrl_if;
  import dtmr_pkg::*;
  logic             act_req;
  logic [NCOPY-1:0] fault;
  logic             state;
  logic [NCOPY-1:0] rec_rst;
  logic [NCOPY-1:0] perm_fail;
  logic             alarm;
  logic             busy;

  modport master (output act_req, fault,
                  input  state, rec_rst, perm_fail, alarm, busy);
  modport slave  (input  act_req, fault,
                  output state, rec_rst, perm_fail, alarm, busy);
endinterface

// File: rtl/dtmr_fault_ctrl_persist_cnt.sv
// Saturating persistence counter for one copy's fault flag.
// hit means the flag has been high for PERSIST counted cycles; zero means idle.
module fault_persist_cnt import dtmr_pkg::*; #(
  parameter int PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic flt,
  input  logic clr,
  output logic hit,
  output logic zero
);
  localparam int W = cw(PERSIST + 1);
  logic [W-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc <= '0;
    else if (clr)    pc <= '0;
    else if (en)     pc <= !flt ? '0 : (pc == W'(PERSIST)) ? pc : pc + 1'b1;
  end

  assign hit  = (pc == W'(PERSIST));
  assign zero = (pc == '0);
endmodule

// File: rtl/dtmr_fault_ctrl.sv
// DTMR loop controller: simplex/TMR mode, per-copy fault filtering,
// timed recovery resets, retirement of repeat offenders and a terminal failsafe.
module dtmr_fault_ctrl import dtmr_pkg::*; #(
  parameter int PERSIST = 4,
  parameter int REC_CYC = 8,
  parameter int MAX_REC = 3
) (
  input logic               clk,
  input logic               rst_n,
  dtmr_fault_ctrl_if.slave  bus
);
  localparam int PW = cw(PERSIST + 1);
  localparam int RW = cw(MAX_REC + 1);
  localparam int CW = cw(REC_CYC);
  localparam int IW = cw(NCOPY);

  fsm_e                      st;
  logic                      state_q, alarm_q, busy_q;
  logic [NCOPY-1:0]          rec_rst_q, pf;
  logic [NCOPY-1:0][RW-1:0]  rc;
  logic [CW-1:0]             rcnt;
  logic [IW-1:0]             who, hsel;
  logic [PW-1:0]             all_cnt;
  logic [NCOPY-1:0]          hit, zero, clr;
  logic                      hany, rec_done, multi_pf, en_tmr;
  logic [RW-1:0]             rc_inc;

  assign en_tmr   = (st == ST_TMR);
  assign rec_done = (st == ST_RECOVER) && (rcnt == CW'(REC_CYC - 1));
  assign multi_pf = ($countones(pf) >= 2);
  assign rc_inc   = (rc[who] == RW'(MAX_REC)) ? rc[who] : rc[who] + 1'b1;

  // Retired copies are masked so they can never reach hit again.
  for (genvar i = 0; i < NCOPY; i++) begin : g_copy
    assign clr[i] = rec_done && (who == IW'(i));
    fault_persist_cnt #(.PERSIST(PERSIST)) u_pc (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en_tmr),
      .flt  (bus.fault[i] & ~pf[i]),
      .clr  (clr[i]),
      .hit  (hit[i]),
      .zero (zero[i])
    );
  end

  always_comb begin
    hsel = '0;
    hany = 1'b0;
    for (int i = NCOPY - 1; i >= 0; i--) begin
      if (hit[i] && !pf[i]) begin
        hsel = IW'(i);
        hany = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_SIMPLEX;
      state_q   <= 1'b0;
      rec_rst_q <= '0;
      pf        <= '0;
      alarm_q   <= 1'b0;
      busy_q    <= 1'b0;
      rc        <= '0;
      rcnt      <= '0;
      who       <= '0;
      all_cnt   <= '0;
    end else begin
      case (st)
        ST_SIMPLEX: if (bus.act_req) begin
          st      <= ST_TMR;
          state_q <= 1'b1;
        end
        ST_TMR: begin
          all_cnt <= (bus.fault != '1) ? '0 :
                     (all_cnt == PW'(PERSIST)) ? all_cnt : all_cnt + 1'b1;
          // Loss of majority outranks any single-copy recovery.
          if (multi_pf || all_cnt == PW'(PERSIST)) begin
            st      <= ST_FAILSAFE;
            alarm_q <= 1'b1;
          end else if (hany) begin
            st        <= ST_RECOVER;
            who       <= hsel;
            rcnt      <= '0;
            rec_rst_q <= {{(NCOPY-1){1'b0}}, 1'b1} << hsel;
            busy_q    <= 1'b1;
          end else if (!bus.act_req && (&zero)) begin
            st      <= ST_SIMPLEX;
            state_q <= 1'b0;
            all_cnt <= '0;
          end
        end
        ST_RECOVER: begin
          if (rec_done) begin
            st        <= ST_TMR;
            rec_rst_q <= '0;
            busy_q    <= 1'b0;
            rc[who]   <= rc_inc;
            if (rc_inc == RW'(MAX_REC)) pf[who] <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.rec_rst   = rec_rst_q;
  assign bus.perm_fail = pf;
  assign bus.alarm     = alarm_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dtmr_fault_ctrl.sv
// Self-checking bench for dtmr_fault_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_dtmr_fault_ctrl;
  localparam int PERSIST = 4;
  localparam int REC_CYC = 8;
  localparam int MAX_REC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dtmr_fault_ctrl_if bus();
  dtmr_fault_ctrl #(.PERSIST(PERSIST), .REC_CYC(REC_CYC), .MAX_REC(MAX_REC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural model: mode plus plain integer bookkeeping.
  typedef enum {M_SIMPLEX, M_TMR, M_REC, M_FS} mmode_e;
  mmode_e   m_mode;
  int       m_pc[3], m_rc[3];
  bit [2:0] m_pf;
  int       m_run, m_left, m_who;

  function automatic void model_reset();
    m_mode = M_SIMPLEX; m_pf = '0; m_run = 0; m_left = 0; m_who = 0;
    for (int i = 0; i < 3; i++) begin m_pc[i] = 0; m_rc[i] = 0; end
  endfunction

  function automatic void model_edge(input bit act, input bit [2:0] f);
    int npc[3];
    int nrun, sel, tot;
    case (m_mode)
      M_SIMPLEX: if (act) m_mode = M_TMR;
      M_TMR: begin
        sel = -1; tot = 0;
        for (int i = 0; i < 3; i++) begin
          npc[i] = (f[i] && !m_pf[i]) ? ((m_pc[i] < PERSIST) ? m_pc[i] + 1 : PERSIST) : 0;
          tot += m_pc[i];
        end
        nrun = (f == 3'b111) ? ((m_run < PERSIST) ? m_run + 1 : PERSIST) : 0;
        for (int i = 2; i >= 0; i--) if (m_pc[i] == PERSIST && !m_pf[i]) sel = i;
        if ($countones(m_pf) >= 2 || m_run == PERSIST) m_mode = M_FS;
        else if (sel >= 0) begin m_mode = M_REC; m_who = sel; m_left = REC_CYC; end
        else if (!act && tot == 0) begin m_mode = M_SIMPLEX; nrun = 0; end
        for (int i = 0; i < 3; i++) m_pc[i] = npc[i];
        m_run = nrun;
      end
      M_REC: begin
        m_left--;
        if (m_left == 0) begin
          m_pc[m_who] = 0;
          if (m_rc[m_who] < MAX_REC) m_rc[m_who]++;
          if (m_rc[m_who] == MAX_REC) m_pf[m_who] = 1'b1;
          m_mode = M_TMR;
        end
      end
      default: ;
    endcase
  endfunction

  // {state, rec_rst, perm_fail, alarm, busy}
  function automatic logic [8:0] m_out();
    logic [2:0] rr;
    rr = (m_mode == M_REC) ? (3'b001 << m_who) : 3'b000;
    return {m_mode != M_SIMPLEX, rr, m_pf, m_mode == M_FS, m_mode == M_REC};
  endfunction

  function automatic logic [8:0] d_out();
    return {bus.state, bus.rec_rst, bus.perm_fail, bus.alarm, bus.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(bus.act_req, bus.fault);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.act_req = 1'b0; bus.fault = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; #1;
    n_chk++;
    if (d_out() !== 9'd0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", d_out(), 9'd0); end
    #1 rst_n = 1'b1;
    bus.fault = 3'b010;
    for (int c = 0; c < 20; c++) begin
      tick(); n_chk++;
      if (bus.state !== 1'b0 || bus.rec_rst !== 3'b000 || d_out() !== m_out()) begin
        n_fail++; $display("FAIL simplex_ignore cyc=%0d got=%b exp=%b", c, d_out(), m_out());
      end
    end
  endtask

  task automatic test_activate_transient();
    int seen;
    bus.fault = 3'b000; bus.act_req = 1'b1;
    tick(); n_chk++;
    if (bus.state !== 1'b1 || d_out() !== m_out()) begin
      n_fail++; $display("FAIL activate got=%b exp_state=1 model=%b", d_out(), m_out());
    end
    seen = 0;
    bus.fault = 3'b010;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) bus.fault = 3'b000;
      tick();
      if (bus.rec_rst != 3'b000) seen++;
      n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL transient cyc=%0d got=%b exp=%b", c, d_out(), m_out()); end
    end
    n_chk++;
    if (seen !== 0) begin n_fail++; $display("FAIL transient_filter rec_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_recover();
    int first, nrec, nbusy;
    first = -1; nrec = 0; nbusy = 0;
    bus.fault = 3'b100;
    for (int c = 1; c <= 22; c++) begin
      if (c == 7) bus.fault = 3'b000;
      tick();
      if (bus.rec_rst == 3'b100) begin nrec++; if (first < 0) first = c; end
      if (bus.busy) nbusy++;
      n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL recover cyc=%0d got=%b exp=%b", c, d_out(), m_out()); end
    end
    n_chk++;
    if (first !== PERSIST + 1) begin n_fail++; $display("FAIL recover_start got=%0d exp=%0d", first, PERSIST + 1); end
    n_chk++;
    if (nrec !== REC_CYC || nbusy !== REC_CYC) begin
      n_fail++; $display("FAIL recover_len rec=%0d busy=%0d exp=%0d", nrec, nbusy, REC_CYC);
    end
    n_chk++;
    if (bus.state !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL recover_return got=%b", d_out()); end
  endtask

  // Hold one copy's fault until it is retired; count its recovery episodes.
  task automatic retire_copy(input int k, input string nm);
    int rises, c;
    bit prev;
    rises = 0; prev = 1'b0; c = 0;
    bus.fault = 3'b001 << k;
    while (!bus.perm_fail[k] && c < 200) begin
      tick(); c++;
      if (bus.rec_rst[k] && !prev) rises++;
      prev = bus.rec_rst[k];
      n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL %s cyc=%0d got=%b exp=%b", nm, c, d_out(), m_out()); end
    end
    n_chk++;
    if (!bus.perm_fail[k] || rises !== MAX_REC) begin
      n_fail++; $display("FAIL %s_count perm=%b rises=%0d exp=%0d", nm, bus.perm_fail, rises, MAX_REC);
    end
  endtask

  task automatic test_retire();
    int bad;
    retire_copy(0, "retire1");
    n_chk++;
    if (bus.perm_fail !== 3'b001) begin n_fail++; $display("FAIL retire1_flag got=%b exp=001", bus.perm_fail); end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.rec_rst != 3'b000 || bus.busy) bad++;
      n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL retire1_mask cyc=%0d got=%b exp=%b", c, d_out(), m_out()); end
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL retired_ignored recov_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_failsafe();
    retire_copy(1, "retire2");
    tick(); n_chk++;
    if (bus.alarm !== 1'b1 || bus.state !== 1'b1 || d_out() !== m_out()) begin
      n_fail++; $display("FAIL failsafe_enter got=%b exp=%b", d_out(), m_out());
    end
    bus.act_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.fault = 3'($urandom_range(0, 7));
      tick(); n_chk++;
      if (bus.alarm !== 1'b1 || bus.state !== 1'b1 || bus.rec_rst !== 3'b000 || d_out() !== m_out()) begin
        n_fail++; $display("FAIL failsafe_hold cyc=%0d got=%b exp=%b", c, d_out(), m_out());
      end
    end
    do_reset(); n_chk++;
    if (d_out() !== 9'd0) begin n_fail++; $display("FAIL failsafe_clear got=%b exp=0", d_out()); end
  endtask

  task automatic test_triple();
    do_reset();
    bus.act_req = 1'b1; tick();
    bus.fault = 3'b111;
    for (int c = 0; c < PERSIST + 4; c++) begin
      tick(); n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL triple cyc=%0d got=%b exp=%b", c, d_out(), m_out()); end
    end
    n_chk++;
    if (bus.alarm !== 1'b1 || bus.rec_rst !== 3'b000) begin n_fail++; $display("FAIL triple_alarm got=%b", d_out()); end
  endtask

  task automatic test_tie_and_reset();
    logic [2:0] order[$];
    int c;
    do_reset();
    bus.act_req = 1'b1; tick();
    bus.fault = 3'b011;
    c = 0;
    while (order.size() < 2 && c < 60) begin
      tick(); c++;
      if (bus.rec_rst != 3'b000 && (order.size() == 0 || order[$] != bus.rec_rst)) order.push_back(bus.rec_rst);
      n_chk++;
      if (d_out() !== m_out()) begin n_fail++; $display("FAIL tie cyc=%0d got=%b exp=%b", c, d_out(), m_out()); end
    end
    n_chk++;
    if (order.size() != 2 || order[0] !== 3'b001 || order[1] !== 3'b010) begin
      n_fail++; $display("FAIL tie_order n=%0d first=%b second=%b exp=001,010", order.size(),
        (order.size() > 0) ? order[0] : 3'bxxx, (order.size() > 1) ? order[1] : 3'bxxx);
    end
    #2 rst_n = 1'b0; model_reset(); #1;
    n_chk++;
    if (d_out() !== 9'd0) begin n_fail++; $display("FAIL async_reset got=%b exp=0", d_out()); end
    do_reset();
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      bus.act_req = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 5))
        0:       bus.fault = 3'b000;
        1:       bus.fault = 3'b111;
        2:       bus.fault = 3'($urandom_range(0, 7));
        default: bus.fault = 3'b001 << $urandom_range(0, 2);
      endcase
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        tick(); n_chk++;
        if (d_out() !== m_out()) begin n_fail++; $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b", s, c, d_out(), m_out()); end
      end
    end
  endtask

  initial begin
    bus.act_req = 1'b0;
    bus.fault = 3'b000;
    model_reset();
    test_reset();
    test_activate_transient();
    test_recover();
    test_retire();
    test_failsafe();
    test_triple();
    test_tie_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
